// File: rtl/feeder_pkg.sv
// feeder_pkg: shared definitions for the instruction feeder.
//   - opcode constants of the processor's 16-bit instruction word
//   - FSM state encoding
//   - field-slice macros: FEEDER_OPCODE(w) = w[3:0], FEEDER_X(w) = w[6:4], FEEDER_Y(w) = w[9:7]
//     (argument must be a plain identifier)
// Configuration macro honoured by the design: FEEDER_WDOG_EN (see instr_feeder).
`ifndef FEEDER_PKG_SV
`define FEEDER_PKG_SV

`define FEEDER_OPCODE(w) w[3:0]
`define FEEDER_X(w) w[6:4]
`define FEEDER_Y(w) w[9:7]

package feeder_pkg;

    localparam logic [3:0] OP_MV   = 4'h0;
    localparam logic [3:0] OP_MVI  = 4'h1;  // next word is the immediate
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_SLL  = 4'h7;
    localparam logic [3:0] OP_SRL  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_RUN   = 3'd2,
        ST_IMM   = 3'd3,
        ST_HALT  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

endpackage

`endif

// File: rtl/feeder_fifo.sv
// feeder_fifo: synchronous 16-bit prefetch FIFO with show-ahead head output.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (pointers/count only)
//   i_push, i_data : write a word (ignored while i_flush)
//   i_pop          : drop the head word (ignored while i_flush or empty)
//   i_flush        : empty the FIFO; wins over push and pop in the same cycle
//   o_head         : word at the head, valid when o_empty is 0
//   o_count        : current occupancy
//   o_empty        : occupancy is zero
// DEPTH must be a power of two so the pointers wrap naturally.
module feeder_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_push,
    input  logic [15:0]                  i_data,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output logic [15:0]                  o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [15:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && !i_flush;
    assign w_pop   = i_pop && !i_flush && (r_count != '0);
    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;  // none, or push+pop together
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/instr_feeder.sv
// instr_feeder: fetches instruction words from a synchronous program ROM into a
// prefetch FIFO and hands them to a multi-cycle processor on DIN exactly in the
// cycles the processor latches them (first RUN cycle, cycle after Done, and the
// cycle after an MVI for its immediate). Controls the processor via Run/proc_resetn.
// Ports:
//   Clock, Resetn      : clock, asynchronous active-low reset
//   Start              : pulse; flush, pc=START_ADDR, (re)start the program
//   mem_rd, mem_addr   : ROM read strobe/address
//   mem_rdata          : ROM data, valid one cycle after mem_rd
//   DIN                : word to the processor
//   Run, proc_resetn   : processor run enable / active-low processor reset
//   Done               : processor end-of-instruction (combinational, last step)
//   busy, halted, fault: status
// Optional feature: define FEEDER_WDOG_EN to enable the Done watchdog (FAULT state).
module instr_feeder
    import feeder_pkg::*;
#(
    parameter int AW          = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int START_ADDR  = 0,
    parameter int WDOG_CYCLES = 16
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Start,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [15:0]   mem_rdata,
    output logic [15:0]   DIN,
    output logic          Run,
    output logic          proc_resetn,
    input  logic          Done,
    output logic          busy,
    output logic          halted,
    output logic          fault
);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_pc;
    logic          r_inflight;
    logic          r_bnd;
    logic          w_bnd_nxt;
    logic [15:0]   r_din;
    logic [15:0]   w_head;
    logic [CW-1:0] w_count;
    logic [CW:0]   w_occ;
    logic          w_empty;
    logic          w_pop;
    logic          w_flush;
    logic          w_present;
    logic          w_busy_st;
    logic          w_bnd;
    logic          w_fetch_en;

    feeder_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (Clock),
        .i_rst_n (Resetn),
        .i_push  (r_inflight),
        .i_data  (mem_rdata),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    assign w_busy_st = (r_state == ST_PRIME) || (r_state == ST_RUN) || (r_state == ST_IMM);
    assign w_bnd     = (r_state == ST_RUN) && r_bnd;

`ifdef FEEDER_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES+1);
    logic [WW-1:0] r_wdog;
    logic          w_wdog_trip;

    // r_wdog holds k-1 in the k-th cycle after a boundary, so tripping at
    // WDOG_CYCLES-2 makes fault visible exactly WDOG_CYCLES cycles after it.
    assign w_wdog_trip = (((r_state == ST_RUN) && !r_bnd) || (r_state == ST_IMM)) &&
                         (r_wdog == WW'(WDOG_CYCLES-2));

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)
            r_wdog <= '0;
        else if (w_bnd || !((r_state == ST_RUN) || (r_state == ST_IMM)))
            r_wdog <= '0;
        else
            r_wdog <= r_wdog + 1'b1;
    end

    assign fault = (r_state == ST_FAULT);
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_bnd_nxt   = 1'b0;
        w_pop       = 1'b0;
        w_present   = 1'b0;
        Run         = 1'b0;
        proc_resetn = 1'b0;
        case (r_state)
            ST_IDLE: ;
            ST_PRIME: begin
                if (w_count >= CW'(2)) begin
                    w_state_nxt = ST_RUN;
                    w_bnd_nxt   = 1'b1;
                end
            end
            ST_RUN: begin
                Run         = 1'b1;
                proc_resetn = 1'b1;
                w_bnd_nxt   = Done;
                if (w_bnd) begin
                    if (w_empty) begin
                        // Underflow: hold the processor in reset and re-prime.
                        Run         = 1'b0;
                        proc_resetn = 1'b0;
                        w_bnd_nxt   = 1'b0;
                        w_state_nxt = ST_PRIME;
                    end else begin
                        w_pop     = 1'b1;
                        w_present = 1'b1;
                        if (`FEEDER_OPCODE(w_head) == OP_MVI) begin
                            w_state_nxt = ST_IMM;
                            w_bnd_nxt   = 1'b0;
                        end else if (`FEEDER_OPCODE(w_head) == OP_HALT) begin
                            Run         = 1'b0;
                            proc_resetn = 1'b0;
                            w_bnd_nxt   = 1'b0;
                            w_state_nxt = ST_HALT;
                        end
                    end
                end
            end
            ST_IMM: begin
                Run         = 1'b1;
                proc_resetn = 1'b1;
                if (w_empty) begin
                    Run         = 1'b0;
                    proc_resetn = 1'b0;
                    w_state_nxt = ST_PRIME;
                end else begin
                    w_pop       = 1'b1;
                    w_present   = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_HALT:  ;
            ST_FAULT: ;
            default:  w_state_nxt = ST_IDLE;
        endcase
`ifdef FEEDER_WDOG_EN
        if (w_wdog_trip) begin
            Run         = 1'b0;
            proc_resetn = 1'b0;
            w_bnd_nxt   = 1'b0;
            w_state_nxt = ST_FAULT;
        end
`endif
        if (Start) begin
            w_state_nxt = ST_PRIME;
            w_bnd_nxt   = 1'b0;
        end
    end

    // Flushing on Start also discards the in-flight read (push is gated by flush).
    assign w_flush = Start || (w_state_nxt == ST_HALT) || (w_state_nxt == ST_FAULT);

    // No read is issued in a cycle that leaves the fetching states or restarts,
    // so pc stops exactly at the last useful word.
    assign w_fetch_en = w_busy_st && !Start &&
                        ((w_state_nxt == ST_PRIME) || (w_state_nxt == ST_RUN) || (w_state_nxt == ST_IMM));
    assign w_occ      = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign mem_rd     = w_fetch_en && (w_occ < (CW+1)'(FIFO_DEPTH));
    assign mem_addr   = r_pc;

    assign DIN    = w_present ? w_head : r_din;
    assign busy   = w_busy_st;
    assign halted = (r_state == ST_HALT);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state    <= ST_IDLE;
            r_pc       <= AW'(START_ADDR);
            r_inflight <= 1'b0;
            r_bnd      <= 1'b0;
            r_din      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_bnd      <= w_bnd_nxt;
            r_inflight <= mem_rd;
            if (Start)
                r_pc <= AW'(START_ADDR);
            else if (mem_rd)
                r_pc <= r_pc + 1'b1;
            if (w_present)
                r_din <= w_head;
        end
    end

endmodule

// File: tb/tb_instr_feeder.sv
module tb_instr_feeder;

    logic        clk = 1'b0;
    logic        Resetn;
    logic        Start;
    logic        Done;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata = 16'h0000;
    logic [15:0] DIN;
    logic        Run;
    logic        proc_resetn;
    logic        busy;
    logic        halted;
    logic        fault;

    logic [15:0] rom [256];
    int n_checks = 0;
    int n_err    = 0;

    instr_feeder #(.AW(8), .FIFO_DEPTH(4), .START_ADDR(0), .WDOG_CYCLES(16)) dut (
        .Clock       (clk),
        .Resetn      (Resetn),
        .Start       (Start),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .DIN         (DIN),
        .Run         (Run),
        .proc_resetn (proc_resetn),
        .Done        (Done),
        .busy        (busy),
        .halted      (halted),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data one cycle after the read strobe.
    always @(posedge clk) if (mem_rd) mem_rdata <= rom[mem_addr];

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs for the new cycle are applied 1 after the edge,
    // outputs are settled and checked 2 after the edge.
    task automatic cyc(input logic d, input logic s);
        @(posedge clk);
        #1;
        Done  = d;
        Start = s;
        #1;
    endtask

    task automatic wait_run(input string tag);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b0);
            if (Run === 1'b1) break;
        end
        check(tag, {15'd0, Run}, 16'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_rd"},   {15'd0, mem_rd}, 16'd0);
        check({tag, "_mem_addr"}, {8'd0, mem_addr}, 16'd0);
        check({tag, "_DIN"},      DIN, 16'h0000);
        check({tag, "_Run"},      {15'd0, Run}, 16'd0);
        check({tag, "_presetn"},  {15'd0, proc_resetn}, 16'd0);
        check({tag, "_busy"},     {15'd0, busy}, 16'd0);
        check({tag, "_halted"},   {15'd0, halted}, 16'd0);
        check({tag, "_fault"},    {15'd0, fault}, 16'd0);
    endtask

    logic [15:0] t2_din [3];
    logic        t3_done [10];
    logic [15:0] t3_din [10];
    logic [7:0]  held_addr;

    initial begin
        Resetn = 1'b0;
        Start  = 1'b0;
        Done   = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        Resetn = 1'b1;

        // Test 1: mvi R0,5 ; halt
        rom[0] = 16'h0001; rom[1] = 16'h0005; rom[2] = 16'h000F;
        cyc(1'b0, 1'b1);
        wait_run("t1_run");
        check("t1_din_mvi", DIN, 16'h0001);
        check("t1_presetn", {15'd0, proc_resetn}, 16'd1);
        check("t1_busy", {15'd0, busy}, 16'd1);
        cyc(1'b0, 1'b0);
        check("t1_din_imm", DIN, 16'h0005);
        cyc(1'b1, 1'b0);
        check("t1_din_hold", DIN, 16'h0005);
        check("t1_run_done", {15'd0, Run}, 16'd1);
        cyc(1'b0, 1'b0);
        check("t1_halt_run", {15'd0, Run}, 16'd0);
        check("t1_halt_presetn", {15'd0, proc_resetn}, 16'd0);
        cyc(1'b0, 1'b0);
        check("t1_halted", {15'd0, halted}, 16'd1);
        check("t1_busy_off", {15'd0, busy}, 16'd0);
        check("t1_no_fetch", {15'd0, mem_rd}, 16'd0);
        held_addr = mem_addr;
        cyc(1'b0, 1'b0);
        check("t1_pc_stopped", {8'd0, mem_addr}, {8'd0, held_addr});

        // Test 2: three mv words, Done every 2nd RUN cycle, then halt
        rom[0] = 16'h0010; rom[1] = 16'h0020; rom[2] = 16'h0030; rom[3] = 16'h000F;
        t2_din[0] = 16'h0010; t2_din[1] = 16'h0020; t2_din[2] = 16'h0030;
        cyc(1'b0, 1'b1);
        check("t2_halted_clr", {15'd0, halted}, 16'd1);
        cyc(1'b0, 1'b0);
        check("t2_halted_cleared", {15'd0, halted}, 16'd0);
        wait_run("t2_run");
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t2_din_pop%0d", k), DIN, t2_din[k]);
            check($sformatf("t2_run_pop%0d", k), {15'd0, Run}, 16'd1);
            cyc(1'b1, 1'b0);
            check($sformatf("t2_din_hold%0d", k), DIN, t2_din[k]);
            check($sformatf("t2_run_hold%0d", k), {15'd0, Run}, 16'd1);
            cyc(1'b0, 1'b0);
        end
        check("t2_halt_run", {15'd0, Run}, 16'd0);
        check("t2_halt_din", DIN, 16'h000F);
        cyc(1'b0, 1'b0);
        check("t2_halted", {15'd0, halted}, 16'd1);

        // Test 3: mvi,mvi,add,halt with a processor model (mvi 3 cycles incl. imm, add 3 cycles)
        rom[0] = 16'h0001; rom[1] = 16'h0005; rom[2] = 16'h0001;
        rom[3] = 16'h0007; rom[4] = 16'h0082; rom[5] = 16'h000F;
        t3_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        t3_din  = '{16'h0001, 16'h0005, 16'h0005, 16'h0001, 16'h0007,
                    16'h0007, 16'h0082, 16'h0082, 16'h0082, 16'h000F};
        cyc(1'b0, 1'b1);
        wait_run("t3_run");
        for (int k = 0; k < 10; k++) begin
            if (k > 0) cyc(t3_done[k], 1'b0);
            check($sformatf("t3_din_c%0d", k), DIN, t3_din[k]);
            check($sformatf("t3_run_c%0d", k), {15'd0, Run}, (k < 9) ? 16'd1 : 16'd0);
        end
        cyc(1'b0, 1'b0);
        check("t3_halted", {15'd0, halted}, 16'd1);

        // Test 4: Start while running at pc=5
        for (int i = 0; i < 16; i++) rom[i] = 16'h0100 + 16'(i);
        cyc(1'b0, 1'b1);
        wait_run("t4_run");
        for (int i = 0; i < 20; i++) begin
            if (mem_addr == 8'd5) break;
            cyc(1'(i % 2 == 0), 1'b0);
        end
        check("t4_reach_pc5", {8'd0, mem_addr}, 16'd5);
        Done  = 1'b0;
        Start = 1'b1;
        #1;
        check("t4_no_read_on_start", {15'd0, mem_rd}, 16'd0);
        cyc(1'b0, 1'b0);
        check("t4_addr_restart", {8'd0, mem_addr}, 16'd0);
        check("t4_presetn_low1", {15'd0, proc_resetn}, 16'd0);
        check("t4_run_low", {15'd0, Run}, 16'd0);
        check("t4_busy", {15'd0, busy}, 16'd1);
        cyc(1'b0, 1'b0);
        check("t4_presetn_low2", {15'd0, proc_resetn}, 16'd0);
        check("t4_addr_next", {8'd0, mem_addr}, 16'd1);
        wait_run("t4_rerun");
        check("t4_first_word", DIN, 16'h0100);
        Resetn = 1'b0;
        #1;
        Resetn = 1'b1;

        // Test 5: asynchronous reset during IMM
        rom[0] = 16'h0001; rom[1] = 16'h0005; rom[2] = 16'h000F;
        cyc(1'b0, 1'b1);
        wait_run("t5_run");
        cyc(1'b0, 1'b0);
        check("t5_in_imm", DIN, 16'h0005);
        Resetn = 1'b0;
        #1;
        check_reset_outputs("t5");
        @(posedge clk);
        #1;
        Resetn = 1'b1;

        // Test 6: ld word, Done never asserted
        rom[0] = 16'h0009;
        for (int i = 1; i < 8; i++) rom[i] = 16'h0000;
        cyc(1'b0, 1'b1);
        wait_run("t6_run");
        check("t6_din_ld", DIN, 16'h0009);
`ifdef FEEDER_WDOG_EN
        for (int k = 1; k < 16; k++) cyc(1'b0, 1'b0);
        check("t6_fault_before", {15'd0, fault}, 16'd0);
        check("t6_run_before", {15'd0, Run}, 16'd1);
        cyc(1'b0, 1'b0);
        check("t6_fault", {15'd0, fault}, 16'd1);
        check("t6_presetn", {15'd0, proc_resetn}, 16'd0);
        check("t6_run_off", {15'd0, Run}, 16'd0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        check("t6_fault_cleared", {15'd0, fault}, 16'd0);
        check("t6_busy", {15'd0, busy}, 16'd1);
`else
        for (int k = 1; k < 30; k++) cyc(1'b0, 1'b0);
        check("t6_no_fault", {15'd0, fault}, 16'd0);
        check("t6_still_run", {15'd0, Run}, 16'd1);
        check("t6_presetn_high", {15'd0, proc_resetn}, 16'd1);
        check("t6_din_held", DIN, 16'h0009);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
